// File: rtl/ground_scroll_scheduler.sv
// ground_scroll_scheduler
//   Per-frame sequencer for the two leap-frogging ground segments of the
//   scrolling horizon. It tracks the game state, owns both segment X offsets,
//   ramps the scroll speed over play time and publishes the current speed so
//   the obstacle and cloud delegates scroll in lock-step.
//
//   Optional feature: define ODOMETER_EN to build the 19-bit distance
//   accumulator. When it is left undefined, distance is tied to zero.
module ground_scroll_scheduler #(
    parameter int GROUND_W    = 2400,
    parameter int POS_W       = 13,
    parameter int SPEED_INIT  = 6,
    parameter int SPEED_STEP  = 1,
    parameter int SPEED_MAX   = 30,
    parameter int RAMP_FRAMES = 600
) (
    input  logic                    FrameClk,
    input  logic                    rst,
    input  logic [1:0]              gameState,
    output logic signed [POS_W-1:0] seg1X,
    output logic signed [POS_W-1:0] seg2X,
    output logic [5:0]              speed,
    output logic                    running,
    output logic [15:0]             distance
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FREEZE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        GS_READY    = 2'b00,
        GS_PLAYING  = 2'b01,
        GS_GAMEOVER = 2'b10,
        GS_RESERVED = 2'b11
    } game_t;

    localparam int CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

    localparam logic signed [POS_W-1:0] GW       = POS_W'(GROUND_W);
    localparam logic signed [POS_W-1:0] NEG_GW   = -GW;
    localparam logic [5:0]              SPD_INIT = 6'(SPEED_INIT);
    localparam logic [6:0]              SPD_MAX  = 7'(SPEED_MAX);
    localparam logic [6:0]              SPD_STEP = 7'(SPEED_STEP);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(RAMP_FRAMES - 1);

    state_t                  state;
    logic [CNT_W-1:0]        ramp_cnt;

    game_t                   gs;
    logic                    want_play;
    logic                    want_over;
    logic                    want_ready;
    logic                    scroll_en;
    logic                    reinit;

    logic signed [POS_W-1:0] spd_s;
    logic signed [POS_W-1:0] nx1;
    logic signed [POS_W-1:0] nx2;
    logic signed [POS_W-1:0] nxt1;
    logic signed [POS_W-1:0] nxt2;
    logic                    wrap1;
    logic                    wrap2;

    logic                    ramp_wrap;
    logic [6:0]              spd_sum;
    logic [5:0]              spd_ramped;
    logic [CNT_W-1:0]        cnt_next;

    // Decode the game-state request and derive the per-edge actions.
    always_comb begin
        gs         = game_t'(gameState);
        want_play  = (gs == GS_PLAYING);
        want_over  = (gs == GS_GAMEOVER);
        want_ready = (gs == GS_READY) || (gs == GS_RESERVED);
        // Only an edge that both starts and stays in RUN moves the ground.
        scroll_en  = (state == ST_RUN) && want_play;
        // Reset values are reloaded while idling, on the edge back to IDLE,
        // and on a direct restart out of FREEZE.
        reinit     = (state == ST_IDLE)
                   || ((state == ST_RUN) && want_ready)
                   || ((state == ST_FREEZE) && (want_play || want_ready));
    end

    // Next segment positions, including the leap-frog placement.
    always_comb begin
        spd_s = signed'({{(POS_W-6){1'b0}}, speed});
        nx1   = seg1X - spd_s;
        nx2   = seg2X - spd_s;
        wrap1 = (nx1 <= NEG_GW);
        wrap2 = (nx2 <= NEG_GW);
        nxt1  = nx1;
        nxt2  = nx2;
        // A segment that slides fully off the left is re-placed against the
        // other segment's new position, so the pair never gaps or overlaps.
        // seg1 is resolved first so a double wrap still chains cleanly.
        if (wrap1) begin
            nxt1 = nx2 + GW;
            if (wrap2) begin
                nxt2 = nxt1 + GW;
            end
        end else if (wrap2) begin
            nxt2 = nx1 + GW;
        end
    end

    // Ramp counter wrap and the saturated speed increment.
    always_comb begin
        ramp_wrap = (ramp_cnt == CNT_LAST);
        cnt_next  = ramp_wrap ? '0 : ramp_cnt + CNT_W'(1);
        spd_sum   = {1'b0, speed} + SPD_STEP;
        spd_ramped = (spd_sum > SPD_MAX) ? SPD_MAX[5:0] : spd_sum[5:0];
    end

    // Scheduler FSM with registered positions, speed and running flag.
    always_ff @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            seg1X    <= '0;
            seg2X    <= GW;
            speed    <= SPD_INIT;
            running  <= 1'b0;
            ramp_cnt <= '0;
        end else begin
            if (reinit) begin
                seg1X    <= '0;
                seg2X    <= GW;
                speed    <= SPD_INIT;
                ramp_cnt <= '0;
            end else if (scroll_en) begin
                // The scroll on a ramp edge still uses the old speed.
                seg1X    <= nxt1;
                seg2X    <= nxt2;
                ramp_cnt <= cnt_next;
                if (ramp_wrap) begin
                    speed <= spd_ramped;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (want_play) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (want_over) begin
                        state   <= ST_FREEZE;
                        running <= 1'b0;
                    end else if (want_ready) begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end
                end
                ST_FREEZE: begin
                    if (want_play) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end else if (want_ready) begin
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef ODOMETER_EN
    logic [18:0] odo_acc;
    logic [18:0] odo_next;
    logic [19:0] odo_sum;

    // Saturating add of this frame's scroll distance.
    always_comb begin
        odo_sum  = {1'b0, odo_acc} + 20'(speed);
        odo_next = odo_sum[19] ? '1 : odo_sum[18:0];
    end

    // Odometer accumulator: cleared with the other run state, held in FREEZE.
    always_ff @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            odo_acc <= '0;
        end else if (reinit) begin
            odo_acc <= '0;
        end else if (scroll_en) begin
            odo_acc <= odo_next;
        end
    end

    assign distance = odo_acc[18:3];
`else
    assign distance = '0;
`endif

endmodule

// File: tb/tb_ground_scroll_scheduler.sv
// tb_ground_scroll_scheduler
//   Directed bench for ground_scroll_scheduler with hand-computed expectations.
module tb_ground_scroll_scheduler;

    logic               FrameClk;
    logic               rst;
    logic [1:0]         gameState;
    logic signed [12:0] seg1X;
    logic signed [12:0] seg2X;
    logic [5:0]         speed;
    logic               running;
    logic [15:0]        distance;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int inv_viol = 0;
    int max_spd = 0;
    int hold_viol = 0;

    ground_scroll_scheduler #(
        .GROUND_W   (2400),
        .POS_W      (13),
        .SPEED_INIT (6),
        .SPEED_STEP (1),
        .SPEED_MAX  (30),
        .RAMP_FRAMES(600)
    ) dut (
        .FrameClk (FrameClk),
        .rst      (rst),
        .gameState(gameState),
        .seg1X    (seg1X),
        .seg2X    (seg2X),
        .speed    (speed),
        .running  (running),
        .distance (distance)
    );

    initial FrameClk = 1'b0;
    always #5 FrameClk = ~FrameClk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge FrameClk);
            #1;
        end
    endtask

    // Advance scroll edges up to frame index target, watching the segment
    // spacing and the speed ceiling on every edge.
    task automatic run_to(input int target);
        int d;
        while (k < target) begin
            step(1);
            k++;
            d = int'(seg1X) - int'(seg2X);
            if (d != 2400 && d != -2400) inv_viol++;
            if (int'(speed) > max_spd) max_spd = int'(speed);
        end
    endtask

    function automatic int odo(input int scrolled);
`ifdef ODOMETER_EN
        return scrolled / 8;
`else
        return 0 * scrolled;
`endif
    endfunction

    initial begin
        rst       = 1'b1;
        gameState = 2'b00;
        step(2);
        rst = 1'b0;

        check("rst_seg1", seg1X, 0);
        check("rst_seg2", seg2X, 2400);
        check("rst_speed", speed, 6);
        check("rst_running", running, 0);
        check("rst_distance", distance, 0);

        // Entry edge: no movement yet.
        gameState = 2'b01;
        step(1);
        check("entry_seg1", seg1X, 0);
        check("entry_seg2", seg2X, 2400);
        check("entry_running", running, 1);
        k = 0;

        run_to(1);
        check("k1_seg1", seg1X, -6);
        check("k1_seg2", seg2X, 2394);

        run_to(399);
        check("k399_seg1", seg1X, -2394);
        check("k399_seg2", seg2X, 6);
        run_to(400);
        check("wrap_seg1", seg1X, 2400);
        check("wrap_seg2", seg2X, 0);

        run_to(599);
        check("k599_speed", speed, 6);
        run_to(600);
        check("k600_speed", speed, 7);
        check("k600_seg1", seg1X, 1200);
        check("k600_seg2", seg2X, -1200);
        run_to(601);
        check("k601_seg1", seg1X, 1193);
        check("k601_seg2", seg2X, -1207);
        check("k601_distance", distance, odo(3607));
        check("run1_spacing", inv_viol, 0);

        // Freeze: everything held for 50 edges.
        gameState = 2'b10;
        step(1);
        check("frz_running", running, 0);
        check("frz_seg1", seg1X, 1193);
        check("frz_seg2", seg2X, -1207);
        check("frz_speed", speed, 7);
        for (int i = 0; i < 49; i++) begin
            step(1);
            if (seg1X != 1193 || seg2X != -1207 || speed != 7 || running != 1'b0
                || int'(distance) != odo(3607)) hold_viol++;
        end
        check("frz_hold", hold_viol, 0);

        // Direct restart from FREEZE.
        gameState = 2'b01;
        step(1);
        check("rs_seg1", seg1X, 0);
        check("rs_seg2", seg2X, 2400);
        check("rs_speed", speed, 6);
        check("rs_running", running, 1);
        check("rs_distance", distance, 0);
        k = 0;
        inv_viol = 0;
        max_spd = 0;

        run_to(79);
        check("k79_distance", distance, odo(474));
        run_to(80);
        check("k80_distance", distance, odo(480));
        check("k80_seg1", seg1X, -480);
        check("k80_seg2", seg2X, 1920);

        // Ramp counter must have restarted from zero.
        run_to(599);
        check("rs_k599_speed", speed, 6);
        run_to(600);
        check("rs_k600_speed", speed, 7);

        run_to(14399);
        check("k14399_speed", speed, 29);
        run_to(14400);
        check("k14400_speed", speed, 30);
        run_to(16000);
        check("sat_speed", speed, 30);
        check("sat_max_speed", max_spd, 30);
        check("run2_spacing", inv_viol, 0);

        // RUN -> IDLE on the reserved code restores reset values.
        gameState = 2'b11;
        step(1);
        check("idle_seg1", seg1X, 0);
        check("idle_seg2", seg2X, 2400);
        check("idle_speed", speed, 6);
        check("idle_running", running, 0);
        check("idle_distance", distance, 0);
        step(3);
        check("idle_hold_seg2", seg2X, 2400);
        check("idle_hold_running", running, 0);

        // Asynchronous reset in the middle of a run.
        gameState = 2'b01;
        step(1);
        step(5);
        check("k5_seg1", seg1X, -30);
        #2;
        rst = 1'b1;
        #1;
        check("arst_seg1", seg1X, 0);
        check("arst_seg2", seg2X, 2400);
        check("arst_speed", speed, 6);
        check("arst_running", running, 0);
        check("arst_distance", distance, 0);
        gameState = 2'b00;
        rst = 1'b0;
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
